// File: rtl/matload_pkg.sv
// matload_pkg: shared state encoding and sizing constants for the matrix operand loader
package matload_pkg;
  localparam int ELEM_W = 16;
  localparam int N_ELEM = 9;
  localparam int IDX_W = $clog2(N_ELEM);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
endpackage

// File: rtl/element_reg_bank.sv
// element_reg_bank: indexed-write register bank exposing all elements on a flattened bus
module element_reg_bank
  import matload_pkg::*;
#(
  parameter int EW = ELEM_W,
  parameter int NE = N_ELEM,
  parameter int IW = IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IW-1:0]    widx,
  input  logic [EW-1:0]    wdata,
  output logic [NE*EW-1:0] rdata
);
  logic [NE-1:0][EW-1:0] mem;
  always_ff @(posedge clk) begin
    if (!rst_n) mem <= '0;
    else if (we) mem[widx] <= wdata;
  end
  assign rdata = mem;
endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: serial loader assembling A then B 3x3 operands; MATLOAD_ABORT_EN adds abort
module matrix_operand_loader #(
  parameter int ELEM_W = matload_pkg::ELEM_W,
  parameter int N_ELEM = matload_pkg::N_ELEM
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef MATLOAD_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ELEM_W-1:0]        in_data,
  output logic [N_ELEM*ELEM_W-1:0] mat_a,
  output logic [N_ELEM*ELEM_W-1:0] mat_b,
  output logic                     mat_valid,
  input  logic                     mat_ready
);
  import matload_pkg::*;
  localparam int IW = $clog2(N_ELEM);
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic abt, xfer, last;
`ifdef MATLOAD_ABORT_EN
  assign abt = abort;
`else
  assign abt = 1'b0;
`endif
  // abort wins over any same-cycle transfer, so in_ready is masked by it
  always_comb begin
    in_ready = rst_n && !abt && state != HOLD;
    mat_valid = state == HOLD;
    xfer = in_valid && in_ready;
    last = idx == IW'(N_ELEM - 1);
    idx_nx = abt ? '0 : xfer ? (last ? '0 : idx + 1'b1) : idx;
    state_nx = abt ? LOAD_A :
               (mat_valid && mat_ready) ? LOAD_A :
               (xfer && last) ? (state == LOAD_A ? LOAD_B : HOLD) : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD_A;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end
  end
  element_reg_bank #(.EW(ELEM_W), .NE(N_ELEM), .IW(IW)) u_bank_a (
    .clk(clk), .rst_n(rst_n), .we(xfer && state == LOAD_A),
    .widx(idx), .wdata(in_data), .rdata(mat_a)
  );
  element_reg_bank #(.EW(ELEM_W), .NE(N_ELEM), .IW(IW)) u_bank_b (
    .clk(clk), .rst_n(rst_n), .we(xfer && state == LOAD_B),
    .widx(idx), .wdata(in_data), .rdata(mat_b)
  );
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: directed, table-driven checks of the matrix operand loader
module tb_matrix_operand_loader;
  localparam int W = 144;
  logic clk, rst_n, in_valid, in_ready, mat_valid, mat_ready;
  logic [15:0] in_data;
  logic [W-1:0] mat_a, mat_b;
`ifdef MATLOAD_ABORT_EN
  logic abort;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic v;
    logic [15:0] d;
    logic r;
    logic er;
    logic emv;
  } vec_t;
  vec_t vt[40];
  matrix_operand_loader dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MATLOAD_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat_a(mat_a), .mat_b(mat_b), .mat_valid(mat_valid), .mat_ready(mat_ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] seq(input int base);
    logic [W-1:0] m;
    for (int k = 0; k < 9; k++) m[k*16 +: 16] = 16'(base + k);
    return m;
  endfunction
  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    mat_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic run_vecs(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = vt[i].v;
      in_data = vt[i].d;
      mat_ready = vt[i].r;
      #1;
      chk("vec_in_ready", W'(in_ready), W'(vt[i].er));
      chk("vec_mat_valid", W'(mat_valid), W'(vt[i].emv));
      tick;
    end
    in_valid = 1'b0;
  endtask
  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick;
    in_valid = 1'b0;
  endtask
  initial begin
    logic [W-1:0] ea;
    int hits[8];
    int nh;
`ifdef MATLOAD_ABORT_EN
    abort = 1'b0;
`endif
    // reset state
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    mat_ready = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready), '0);
    tick;
    chk("rst_mat_a", mat_a, '0);
    chk("rst_mat_b", mat_b, '0);
    chk("rst_mat_valid", W'(mat_valid), '0);
    do_reset;
    // straight stream 1..18
    for (int i = 0; i < 18; i++) vt[i] = '{1'b1, 16'(i + 1), 1'b0, 1'b1, 1'b0};
    vt[18] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1};
    run_vecs(19);
    chk("load_mat_a", mat_a, seq(1));
    chk("load_mat_b", mat_b, seq(10));
    // hold with mat_ready low for 5 cycles, offered data must be refused
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data = 16'h1234;
      mat_ready = 1'b0;
      #1;
      chk("hold_mat_valid", W'(mat_valid), W'(1));
      chk("hold_in_ready", W'(in_ready), '0);
      chk("hold_mat_a", mat_a, seq(1));
      chk("hold_mat_b", mat_b, seq(10));
      tick;
    end
    mat_ready = 1'b1;
    in_data = 16'hFFFF;
    #1;
    chk("hs_in_ready", W'(in_ready), '0);
    tick;
    mat_ready = 1'b0;
    chk("post_hs_mat_valid", W'(mat_valid), '0);
    chk("post_hs_in_ready", W'(in_ready), W'(1));
    chk("post_hs_mat_a", mat_a, seq(1));
    tick;
    in_valid = 1'b0;
    ea = seq(1);
    ea[15:0] = 16'hFFFF;
    chk("reload_mat_a", mat_a, ea);
    chk("reload_mat_b", mat_b, seq(10));
    // toggling valid: 18 transfers over 36 cycles
    do_reset;
    for (int i = 0; i < 36; i++)
      vt[i] = '{1'(i % 2), (i % 2) ? 16'(i / 2 + 1) : 16'hDEAD, 1'b0, 1'b1, 1'b0};
    run_vecs(36);
    chk("tog_mat_valid", W'(mat_valid), W'(1));
    chk("tog_mat_a", mat_a, seq(1));
    chk("tog_mat_b", mat_b, seq(10));
    // reset after 12 transfers, then a fresh load
    do_reset;
    for (int i = 0; i < 12; i++) send(16'(50 + i));
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", W'(in_ready), '0);
    tick;
    chk("midrst_mat_a", mat_a, '0);
    chk("midrst_mat_b", mat_b, '0);
    chk("midrst_mat_valid", W'(mat_valid), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) send(16'(100 + i));
    chk("fresh_mat_valid", W'(mat_valid), W'(1));
    chk("fresh_mat_a", mat_a, seq(100));
    chk("fresh_mat_b", mat_b, seq(109));
    // back-to-back pairs with mat_ready stuck high
    mat_ready = 1'b1;
    in_valid = 1'b1;
    nh = 0;
    for (int c = 0; c < 58; c++) begin
      in_data = 16'(c);
      if (mat_valid && nh < 8) begin
        hits[nh] = c;
        nh++;
      end
      tick;
    end
    mat_ready = 1'b0;
    in_valid = 1'b0;
    chk("b2b_pairs", W'(nh), W'(4));
    for (int j = 1; j < 4; j++) chk("b2b_period", W'(hits[j] - hits[j-1]), W'(19));
`ifdef MATLOAD_ABORT_EN
    // abort on the 7th element of B
    do_reset;
    for (int i = 0; i < 15; i++) send(16'(1 + i));
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hAAAA;
    #1;
    chk("abort_in_ready", W'(in_ready), '0);
    tick;
    abort = 1'b0;
    in_valid = 1'b0;
    ea = seq(10);
    for (int k = 6; k < 9; k++) ea[k*16 +: 16] = '0;
    chk("abort_mat_b", mat_b, ea);
    chk("abort_mat_valid", W'(mat_valid), '0);
    chk("abort_in_ready_after", W'(in_ready), W'(1));
    send(16'h5555);
    ea = seq(1);
    ea[15:0] = 16'h5555;
    chk("abort_new_a", mat_a, ea);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
